md_issue_ctrl: RTL
==================

Name: md_issue_ctrl

Overview:
- Initiator side of the multiply/divide handshake; sits in the execute stage between the pipeline and the multdiv unit.
- Accepts one mul/div request from the pipeline and latches its operands and destination register.
- Issues a single-cycle ctrl_MULT or ctrl_DIV pulse and holds the operands stable while waiting for data_resultRDY.
- Stalls the pipeline until the result arrives, then presents a one-cycle writeback, with the status-register exception redirect applied.

Parameters:
- REG_ADDR_W, 5: width of the destination register address.
- EXC_REG, 30: register written instead of rd on an exception ($rstatus).
- EXC_CODE_MULT, 4: wb_data value on a multiply exception.
- EXC_CODE_DIV, 5: wb_data value on a divide exception.
- TIMEOUT_CYCLES, 40: watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle.
- req_is_mult  in  1  request is a multiply.
- req_is_div  in  1  request is a divide.
- req_opA  in  32  operand A.
- req_opB  in  32  operand B.
- req_rd  in  REG_ADDR_W  destination register.
- flush  in  1  squash the in-flight operation.
- md_operandA  out  32  operand A to the multdiv unit; held stable.
- md_operandB  out  32  operand B to the multdiv unit; held stable.
- md_ctrl_MULT  out  1  one-cycle multiply start.
- md_ctrl_DIV  out  1  one-cycle divide start.
- md_result  in  32  multdiv result.
- md_exception  in  1  multdiv exception.
- md_resultRDY  in  1  multdiv result ready.
- stall  out  1  freeze upstream pipeline.
- busy  out  1  operation in flight (ISSUE or WAIT).
- wb_valid  out  1  writeback strobe, one cycle.
- wb_rd  out  REG_ADDR_W  writeback register.
- wb_data  out  32  writeback data.
- wb_exc  out  1  writeback is an exception.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State returns to IDLE.
  - All outputs go to 0: operand registers, rd register, result register, wb_*, md_ctrl_*, stall, busy.
  - Reset mid-operation aborts it; a later md_resultRDY is ignored because the state is IDLE.
- Accept condition: req_valid & (req_is_mult | req_is_div) in IDLE or DONE. Both kind bits set means multiply (divide ignored). Requests are ignored in ISSUE and WAIT.
- State IDLE:
  - On accept, latch opA, opB, rd and kind, then go to ISSUE.
  - stall is combinational: it is 1 in the accept cycle and stays 1 until DONE.
- State ISSUE (exactly one cycle):
  - md_ctrl_MULT or md_ctrl_DIV = 1 according to the latched kind.
  - md_resultRDY is ignored this cycle, since it may be stale from the previous operation.
  - Next state: WAIT.
- State WAIT:
  - Hold the md operands; stall=1.
  - When md_resultRDY=1, register md_result and md_exception and go to DONE.
- State DONE (one cycle):
  - wb_valid=1; stall=0.
  - Without exception: wb_rd = latched rd, wb_data = result, wb_exc=0.
  - With exception: wb_rd = EXC_REG, wb_data = EXC_CODE_MULT or EXC_CODE_DIV, wb_exc=1.
  - Next state: ISSUE on a back-to-back accept, otherwise IDLE.
- Latency:
  - Accept edge to ISSUE: 1 cycle.
  - Ready-to-writeback: 1 cycle after the WAIT cycle in which md_resultRDY is seen.
- Flush:
  - In ISSUE or WAIT: go to IDLE; no wb_valid; stall drops the same cycle.
  - In DONE: wb_valid is suppressed.
  - An accept in the same cycle as flush is ignored.
- busy = 1 in ISSUE and WAIT only.
- md_ctrl_* are never asserted outside ISSUE.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- When defined:
  - A 6-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - At TIMEOUT_CYCLES with no md_resultRDY, go to DONE with wb_exc=1, wb_rd=EXC_REG and wb_data=EXC_CODE of the latched kind.
- When undefined: no counter; WAIT holds indefinitely.

Decomposition:
- Shared package md_pkg holds:
  - the state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11);
  - the EXC_CODE_MULT, EXC_CODE_DIV and EXC_REG constants.
- One natural sub-module, md_timeout_cnt: the watchdog counter, instantiated only under MD_TIMEOUT_EN.
- Flop storage uses dffe_ref with an active-low clear wrapper.

Test Plan:
1. Multiply 7 × 6, rd=3; multdiv raises md_resultRDY 4 cycles after ISSUE → exactly one md_ctrl_MULT pulse; stall=1 through WAIT; wb_valid=1, wb_rd=3, wb_data=42, wb_exc=0.
2. Divide 100 / 0, rd=9; md_exception=1 with md_resultRDY → wb_rd=30, wb_data=5, wb_exc=1; md_ctrl_DIV pulses once and md_ctrl_MULT never asserts.
3. Back-to-back: a second multiply presented in the DONE cycle → next cycle is ISSUE with a new MULT pulse; the first writeback is intact; md_resultRDY held high through the ISSUE cycle is ignored.
4. flush during WAIT, then md_resultRDY=1 two cycles later → no wb_valid; stall=0 the cycle after flush; state IDLE.
5. reset_n dropped mid-WAIT with no clock edge → all outputs 0 immediately; a following md_resultRDY produces no writeback.
6. MD_TIMEOUT_EN defined, md_resultRDY never asserted on a multiply → wb_valid exactly 40 WAIT cycles after entry, wb_rd=30, wb_data=4, wb_exc=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared state encoding and exception constants for the mul/div issue controller.
package md_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

  localparam int unsigned MD_EXC_REG       = 30;
  localparam int unsigned MD_EXC_CODE_MULT = 4;
  localparam int unsigned MD_EXC_CODE_DIV  = 5;
  localparam int unsigned MD_TIMEOUT_W     = 6;

endpackage

// File: rtl/dffe_ref.sv
// Enabled register with asynchronous active-low clear; storage primitive for the md datapath.
module dffe_ref #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/md_timeout_cnt.sv
// WAIT-state watchdog: counts consecutive WAIT cycles, flags the LIMIT-th one.
module md_timeout_cnt
  import md_pkg::*;
#(
  parameter int unsigned LIMIT = 40
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic hit_o
);

  logic [MD_TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = run_i & (cnt_q == MD_TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Execute-stage initiator for the multdiv handshake: latch, issue, wait, write back.
// Optional WAIT watchdog enabled by defining MD_TIMEOUT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned EXC_REG        = MD_EXC_REG,
  parameter int unsigned EXC_CODE_MULT  = MD_EXC_CODE_MULT,
  parameter int unsigned EXC_CODE_DIV   = MD_EXC_CODE_DIV,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_is_mult,
  input  logic                  req_is_div,
  input  logic [31:0]           req_opA,
  input  logic [31:0]           req_opB,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  flush,
  output logic [31:0]           md_operandA,
  output logic [31:0]           md_operandB,
  output logic                  md_ctrl_MULT,
  output logic                  md_ctrl_DIV,
  input  logic [31:0]           md_result,
  input  logic                  md_exception,
  input  logic                  md_resultRDY,
  output logic                  stall,
  output logic                  busy,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  output logic                  wb_exc
);

  md_state_e state_q, state_d;

  logic in_idle, in_issue, in_wait, in_done;
  logic accept, cap_en, to_hit, exc_d;
  logic [31:0] opa_q, opb_q, res_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic mult_q, exc_q;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_issue = (state_q == ST_ISSUE);
  assign in_wait  = (state_q == ST_WAIT);
  assign in_done  = (state_q == ST_DONE);

  assign accept = req_valid & (req_is_mult | req_is_div) & ~flush & (in_idle | in_done);
  assign cap_en = in_wait & ~flush & (md_resultRDY | to_hit);
  // A watchdog expiry is recorded as an exception of the latched kind.
  assign exc_d  = md_resultRDY ? md_exception : 1'b1;

  dffe_ref #(.W(32)) u_opa (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(accept), .d_i(req_opA), .q_o(opa_q)
  );
  dffe_ref #(.W(32)) u_opb (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(accept), .d_i(req_opB), .q_o(opb_q)
  );
  dffe_ref #(.W(REG_ADDR_W)) u_rd (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(accept), .d_i(req_rd), .q_o(rd_q)
  );
  dffe_ref #(.W(1)) u_kind (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(accept), .d_i(req_is_mult), .q_o(mult_q)
  );
  dffe_ref #(.W(32)) u_res (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(cap_en), .d_i(md_result), .q_o(res_q)
  );
  dffe_ref #(.W(1)) u_exc (
    .clk_i(clock), .clr_n_i(reset_n), .en_i(cap_en), .d_i(exc_d), .q_o(exc_q)
  );

`ifdef MD_TIMEOUT_EN
  md_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i(clock), .rst_ni(reset_n), .run_i(in_wait), .hit_o(to_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (md_resultRDY || to_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = accept ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md_operandA  = opa_q;
    md_operandB  = opb_q;
    md_ctrl_MULT = in_issue & mult_q;
    md_ctrl_DIV  = in_issue & ~mult_q;
    busy         = in_issue | in_wait;
    // Gated by reset_n so a request held during reset cannot raise stall.
    stall        = reset_n & ((in_idle & accept) | ((in_issue | in_wait) & ~flush));
    wb_valid     = in_done & ~flush;
    wb_exc       = in_done & ~flush & exc_q;
    wb_rd        = '0;
    wb_data      = '0;
    if (in_done && !flush) begin
      if (exc_q) begin
        wb_rd   = REG_ADDR_W'(EXC_REG);
        wb_data = mult_q ? 32'(EXC_CODE_MULT) : 32'(EXC_CODE_DIV);
      end else begin
        wb_rd   = rd_q;
        wb_data = res_q;
      end
    end
  end

endmodule
